// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the timer.
package timer_pkg;

    localparam int TIMER_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_down_counter.sv
// Loadable down counter that saturates at zero and reports a zero flag.
module timer_down_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Load wins over decrement; decrement never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/timer.sv
// Period timer with a single-cycle registered tick on expiry.
// Define TIMER_AUTORELOAD_EN for periodic operation; otherwise it is one-shot.
module timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             count_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clock,
    input  logic             reset,
    output logic             out
);

    state_t           state_d;
    state_t           state_q;
    logic             out_d;
    logic             out_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic [WIDTH-1:0] cnt_load_val;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] cnt;
    logic             cnt_zero;

    // A load of N counts N-1..0, so the tick lands N enabled cycles later.
    assign reload_val = (load_value == '0) ? '0 : (load_value - WIDTH'(1));

    always_comb begin
        state_d      = state_q;
        out_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = reload_val;
        case (state_q)
            IDLE: begin
                if (count_en) begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end
            end
            RUN: begin
                if (count_en) begin
                    if (cnt_zero) begin
                        out_d    = 1'b1;
                        cnt_load = 1'b1;
`ifndef TIMER_AUTORELOAD_EN
                        state_d      = DONE;
                        cnt_load_val = '0;
`endif
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!count_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    timer_down_counter #(
        .WIDTH(WIDTH)
    ) u_down_counter (
        .clock   (clock),
        .reset   (reset),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(cnt_load_val),
        .cnt     (cnt),
        .zero    (cnt_zero)
    );

    assign out = out_q;

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for timer (one-shot or TIMER_AUTORELOAD_EN build).
module tb_timer;
    import timer_pkg::*;

    localparam int W = 9;

    logic         clock;
    logic         reset;
    logic         count_en;
    logic [W-1:0] load_value;
    logic         out;

    int checks;
    int errors;

    timer #(.WIDTH(W)) dut (
        .count_en  (count_en),
        .load_value(load_value),
        .clock     (clock),
        .reset     (reset),
        .out       (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        count_en = 1'b0;
        reset    = 1'b1;
        #2;
        reset    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        count_en   = 1'b0;
        load_value = '0;
        #3;
        checks++;
        if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %0d want 0", out); end
        checks++;
        if (dut.cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.cnt); end
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE); end
        #4;
        reset = 1'b0;
        tick();
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL idle_hold_state got %0d want %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_no_early_tick();
        do_reset();
        load_value = 9'd64;
        count_en   = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (out !== 1'b0) begin errors++; $display("FAIL early_tick edge %0d got %0d want 0", i, out); end
        end
        checks++;
        if (dut.cnt !== 9'd34) begin errors++; $display("FAIL early_cnt got %0d want 34", dut.cnt); end
    endtask

    task automatic test_period64();
        logic exp;
        do_reset();
        load_value = 9'd64;
        count_en   = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick();
`ifdef TIMER_AUTORELOAD_EN
            exp = (i >= 65) && (((i - 65) % 64) == 0);
`else
            exp = (i == 65);
`endif
            checks++;
            if (out !== exp) begin errors++; $display("FAIL period64 edge %0d got %0d want %0d", i, out, exp); end
        end
    endtask

    task automatic test_pause();
        do_reset();
        load_value = 9'd4;
        for (int i = 1; i <= 9; i++) begin
            count_en = !((i >= 3) && (i <= 5));
            if (i == 3) load_value = 9'd9;
            tick();
            checks++;
            if (out !== (i == 8)) begin errors++; $display("FAIL pause_tick edge %0d got %0d want %0d", i, out, (i == 8)); end
            if (i == 5) begin
                checks++;
                if (dut.cnt !== 9'd2) begin errors++; $display("FAIL pause_hold_cnt got %0d want 2", dut.cnt); end
            end
        end
    endtask

    task automatic test_load_zero();
        logic exp;
        do_reset();
        load_value = 9'd0;
        count_en   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
`ifdef TIMER_AUTORELOAD_EN
            exp = (i >= 2);
`else
            exp = (i == 2);
`endif
            checks++;
            if (out !== exp) begin errors++; $display("FAIL load_zero edge %0d got %0d want %0d", i, out, exp); end
        end
    endtask

`ifndef TIMER_AUTORELOAD_EN
    task automatic test_oneshot_rearm();
        do_reset();
        load_value = 9'd4;
        count_en   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (out !== (i == 5)) begin errors++; $display("FAIL oneshot1 edge %0d got %0d want %0d", i, out, (i == 5)); end
        end
        checks++;
        if (dut.state_q !== DONE) begin errors++; $display("FAIL oneshot_done_state got %0d want %0d", dut.state_q, DONE); end
        checks++;
        if (dut.cnt !== '0) begin errors++; $display("FAIL oneshot_done_cnt got %0d want 0", dut.cnt); end
        count_en = 1'b0;
        tick();
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL oneshot_idle_state got %0d want %0d", dut.state_q, IDLE); end
        count_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (out !== (i == 5)) begin errors++; $display("FAIL oneshot2 edge %0d got %0d want %0d", i, out, (i == 5)); end
        end
    endtask
`endif

    task automatic test_reset_midcount();
        do_reset();
        load_value = 9'd64;
        count_en   = 1'b1;
        for (int i = 1; i <= 65; i++) tick();
        checks++;
        if (out !== 1'b1) begin errors++; $display("FAIL midreset_pre_out got %0d want 1", out); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 1'b0) begin errors++; $display("FAIL midreset_out got %0d want 0", out); end
        checks++;
        if (dut.cnt !== '0) begin errors++; $display("FAIL midreset_cnt got %0d want 0", dut.cnt); end
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL midreset_state got %0d want %0d", dut.state_q, IDLE); end
        #1;
        reset    = 1'b0;
        load_value = 9'd3;
        tick();
        checks++;
        if ((dut.state_q !== RUN) || (dut.cnt !== 9'd2)) begin
            errors++;
            $display("FAIL post_reset_load got state %0d cnt %0d want state %0d cnt 2", dut.state_q, dut.cnt, RUN);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_no_early_tick();
        test_period64();
        test_pause();
        test_load_zero();
`ifndef TIMER_AUTORELOAD_EN
        test_oneshot_rearm();
`endif
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
